// File: rtl/wqi_grade_fsm.sv
// wqi_grade_fsm: grades an IEEE-754 single WQI word into a water-quality
// class using a four-step sequential threshold compare (IDLE -> CMP x4 -> OUT).
// The optional persistence alarm is built only when WQI_ALARM_EN is defined;
// without it, alarm is tied to 0.
module wqi_grade_fsm #(
  parameter int ALARM_CLASS = 3,
  parameter int PERSIST     = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_wqi,
  input  logic             in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_class,
  output logic [31:0]      out_wqi,
  output logic             alarm,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [1:0] {IDLE, CMP, OUT} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [2:0]  grade;
  logic [31:0] wqi_q;
  logic        exc_q;
  logic [30:0] thr;
  logic        hit;
  logic        invalid;
  logic [2:0]  grade_fin;
  logic [2:0]  cls_fin;
  logic        load_out;

  assign in_ready = (state == IDLE);

  // Threshold for the current compare step (magnitude bits only).
  always_comb begin
    thr = 31'h42480000;
    case (idx)
      2'd0: thr = 31'h42480000;  // 50
      2'd1: thr = 31'h42C80000;  // 100
      2'd2: thr = 31'h43480000;  // 200
      2'd3: thr = 31'h43960000;  // 300
      default: thr = 31'h42480000;
    endcase
  end

  // Positive finite floats order like their unsigned magnitude bits, so
  // -0.0 and denormals fall below every threshold and grade as 0.
  assign hit       = (wqi_q[30:0] >= thr);
  assign invalid   = exc_q | (wqi_q[30:23] == 8'hFF) | (wqi_q[31] & (|wqi_q[30:0]));
  assign grade_fin = grade + {2'b00, hit};
  assign cls_fin   = invalid ? 3'd7 : grade_fin;
  assign load_out  = (state == CMP) && (idx == 2'd3);

  // Main FSM: accept, four compare cycles, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      grade      <= 3'd0;
      wqi_q      <= 32'd0;
      exc_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_class  <= 3'd0;
      out_wqi    <= 32'd0;
      sample_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          wqi_q <= in_wqi;
          exc_q <= in_exc;
          idx   <= 2'd0;
          grade <= 3'd0;
          state <= CMP;
        end
        CMP: begin
          grade <= grade_fin;
          idx   <= idx + 2'd1;
          if (idx == 2'd3) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_class <= cls_fin;
            out_wqi   <= wqi_q;
          end
        end
        OUT: if (out_ready) begin
          out_valid  <= 1'b0;
          sample_cnt <= sample_cnt + CNT_W'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WQI_ALARM_EN
  localparam logic [2:0] ALARM_CLS3 = 3'(ALARM_CLASS);
  localparam logic [3:0] PERSIST4   = 4'(PERSIST);

  logic [3:0] pcnt;
  logic [3:0] pcnt_nxt;

  // Saturating run length of alarm-worthy grades; any better grade resets it.
  always_comb begin
    pcnt_nxt = 4'd0;
    if (cls_fin >= ALARM_CLS3)
      pcnt_nxt = (pcnt == 4'hF) ? pcnt : pcnt + 4'd1;
  end

  // Counter and alarm move on the same edge that raises out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= 4'd0;
      alarm <= 1'b0;
    end else if (load_out) begin
      pcnt  <= pcnt_nxt;
      alarm <= (pcnt_nxt >= PERSIST4);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{ALARM_CLASS[0], PERSIST[0], load_out};
  assign alarm      = 1'b0;
`endif

endmodule
